// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: derived widths and parameter legality.
package fifo_pkg;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int data_width, input int depth,
                                        input int af_thresh, input int ae_thresh);
        return (data_width >= 1) && is_pow2(depth) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port. Storage is not reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = addr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read/write returns the old word (read-before-write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, sticky
// error flags and synchronous flush.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   d_i,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   d_o,
    output logic                    rd_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int AW = addr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    if (!params_legal(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH)) begin : g_param_err
        $error("sync_fifo_param: illegal parameters DATA_WIDTH=%0d DEPTH=%0d AF=%0d AE=%0d",
               DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH);
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          vld_p1;
    logic          ovf_q;
    logic          unf_q;
    logic          wr_acc;
    logic          rd_acc;
    logic          ovf_set;
    logic          unf_set;

    // Status decodes straight off the registered count.
    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;
    assign rd_valid     = vld_p1;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // Flush masks both requests; a pop frees a slot for a same-cycle push when full.
    assign rd_acc  = rd_en & ~empty & ~flush;
    assign wr_acc  = wr_en & (~full | rd_acc) & ~flush;
    assign ovf_set = wr_en & full & ~rd_acc & ~flush;
    assign unf_set = rd_en & empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            vld_p1 <= rd_acc;
        end
    end

    // Sticky errors: a new error in the clear cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err);
            unf_q <= unf_set | (unf_q & ~clr_err);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (d_i),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (d_o)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed, table-driven bench for sync_fifo_param (8 x 8, AF=6, AE=2).
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] d_i = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] d_o;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;
    logic          clr_err = 1'b0;

    sync_fifo_param #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .AF_THRESH  (6),
        .AE_THRESH  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .d_i          (d_i),
        .rd_en        (rd_en),
        .d_o          (d_o),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         wr;
        bit         rd;
        bit         fl;
        bit         clr;
        logic [7:0] din;
        int         cnt;
        bit         rv;
        logic [7:0] dout;
        bit         ovf;
        bit         unf;
    } vec_t;

    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] last;

    function automatic vec_t mk(bit wr, bit rd, bit fl, bit clr, logic [7:0] din,
                                int cnt, bit rv, logic [7:0] dout, bit ovf, bit unf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.clr = clr; v.din = din;
        v.cnt = cnt; v.rv = rv; v.dout = dout; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // {count, rd_valid, d_o, full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [18:0] expect_bits(int cnt, bit rv, logic [7:0] dout, bit ovf, bit unf);
        logic [3:0] c;
        c = 4'(cnt);
        return {c, rv, dout, (cnt == 8), (cnt == 0), (cnt >= 6), (cnt <= 2), ovf, unf};
    endfunction

    task automatic check(input string name, input logic [18:0] exp_v);
        logic [18:0] act;
        act = {count, rd_valid, d_o, full, empty, almost_full, almost_empty, overflow, underflow};
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got cnt=%0d rv=%b do=%h f=%b e=%b af=%b ae=%b ovf=%b unf=%b, want cnt=%0d rv=%b do=%h f=%b e=%b af=%b ae=%b ovf=%b unf=%b",
                     name, act[18:15], act[14], act[13:6], act[5], act[4], act[3], act[2], act[1], act[0],
                     exp_v[18:15], exp_v[14], exp_v[13:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        wr_en = v.wr; rd_en = v.rd; flush = v.fl; clr_err = v.clr; d_i = v.din;
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; d_i = '0;
        check(name, expect_bits(v.cnt, v.rv, v.dout, v.ovf, v.unf));
    endtask

    initial begin
        last = 8'h00;
        // 1: idle after reset
        repeat (3) vecs.push_back(mk(0,0,0,0,8'h00, 0,0,last,0,0));
        // 2: fill 0x01..0x08, drain in order
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(1,0,0,0,8'(k), k,0,last,0,0));
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(0,1,0,0,8'h00, 8-k,1,8'(k),0,0));
        last = 8'h08;
        // 3: full with simultaneous push/pop
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(1,0,0,0,8'(k), k,0,last,0,0));
        vecs.push_back(mk(1,1,0,0,8'hAA, 8,1,8'h01,0,0));
        for (int k = 2; k <= 8; k++) vecs.push_back(mk(0,1,0,0,8'h00, 9-k,1,8'(k),0,0));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,1,8'hAA,0,0));
        last = 8'hAA;
        // 4: overflow, empty push+pop, underflow, clear semantics
        for (int k = 0; k < 8; k++) vecs.push_back(mk(1,0,0,0,8'(8'h10+k), k+1,0,last,0,0));
        vecs.push_back(mk(1,0,0,0,8'hFF, 8,0,last,1,0));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(0,1,0,0,8'h00, 7-k,1,8'(8'h10+k),1,0));
        vecs.push_back(mk(1,1,0,0,8'h33, 1,0,8'h17,1,1));
        vecs.push_back(mk(0,1,0,0,8'h00, 0,1,8'h33,1,1));
        vecs.push_back(mk(0,1,0,1,8'h00, 0,0,8'h33,0,1));
        vecs.push_back(mk(0,0,0,1,8'h00, 0,0,8'h33,0,0));
        last = 8'h33;
        // 5: pointer wrap
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 5; k++) vecs.push_back(mk(1,0,0,0,8'(8'h40+8*p+k), k+1,0,last,0,0));
            for (int k = 0; k < 5; k++) vecs.push_back(mk(0,1,0,0,8'h00, 4-k,1,8'(8'h40+8*p+k),0,0));
            last = 8'(8'h44 + 8*p);
        end
        for (int k = 0; k < 6; k++) vecs.push_back(mk(1,0,0,0,8'(8'h80+k), k+1,0,last,0,0));
        for (int k = 0; k < 6; k++) vecs.push_back(mk(0,1,0,0,8'h00, 5-k,1,8'(8'h80+k),0,0));

        // reset state while rst is held
        @(posedge clk);
        #1;
        check("reset_hold", expect_bits(0, 0, 8'h00, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        #1;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // flush: drops contents and the flush-cycle write, keeps error flags
        apply(mk(0,1,0,0,8'h00, 0,0,8'h85,0,1), "pre_flush_unf");
        for (int k = 0; k < 4; k++) apply(mk(1,0,0,0,8'(8'h61+k), k+1,0,8'h85,0,1), $sformatf("flush_fill%0d", k));
        apply(mk(1,1,1,0,8'h99, 0,0,8'h85,0,1), "flush");
        apply(mk(1,0,0,0,8'h77, 1,0,8'h85,0,1), "post_flush_wr");
        apply(mk(0,1,0,0,8'h00, 0,1,8'h77,0,1), "post_flush_rd");

        // async reset mid-burst, no clock edge needed
        apply(mk(1,0,0,0,8'h21, 1,0,8'h77,0,1), "burst_w0");
        apply(mk(1,0,0,0,8'h22, 2,0,8'h77,0,1), "burst_w1");
        apply(mk(1,1,0,0,8'h23, 2,1,8'h21,0,1), "burst_wr");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", expect_bits(0, 0, 8'h00, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        apply(mk(0,0,0,0,8'h00, 0,0,8'h00,0,0), "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
